cpu_seq_ctrl: RTL and testbench

- Multi-cycle sequencer for the single-issue RV32I datapath (decoder, regfile, ALU).
- Fetches each instruction from instruction memory over a req/ack handshake and holds it in an instruction register that feeds the decoder.
- Steps each instruction through FETCH/EXEC/WB and gates the regfile write so exactly one write occurs per instruction.
- Maintains PC, a retired-instruction counter, halt on EBREAK, and a fetch watchdog.

---
 rtl/cpu_ctrl_pkg.sv | 24 ++
 rtl/fetch_watchdog.sv | 32 +++
 rtl/cpu_seq_ctrl.sv | 118 +++++++++++
 tb/tb_cpu_seq_ctrl.sv | 289 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/cpu_ctrl_pkg.sv
// Shared definitions for the RV32I multi-cycle sequencer.
// State codes are visible on the state port, so they are fixed.
package cpu_ctrl_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_FETCH = 3'd1,
    ST_EXEC  = 3'd2,
    ST_WB    = 3'd3,
    ST_HALT  = 3'd4,
    ST_FAULT = 3'd5
  } state_e;

  localparam logic [31:0] INST_NOP    = 32'h0000_0013;
  localparam logic [31:0] INST_EBREAK = 32'h0010_0073;
  localparam logic [31:0] PC_STEP     = 32'd4;

  function automatic logic is_ebreak(
    input logic [31:0] w
  );
    return w == INST_EBREAK;
  endfunction

endpackage

// File: rtl/fetch_watchdog.sv
// Counts consecutive un-acked fetch cycles.
// expire_o flags the last allowed cycle; FETCH_TIMEOUT=0 disables it.
module fetch_watchdog #(
  parameter int unsigned FETCH_TIMEOUT = 16
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic clr_i,
  input  logic en_i,
  output logic expire_o
);

  localparam int unsigned CW =
    (FETCH_TIMEOUT > 1) ? $clog2(FETCH_TIMEOUT) : 1;
  localparam logic [CW-1:0] LAST = CW'(FETCH_TIMEOUT - 1);
  localparam logic ENABLED = (FETCH_TIMEOUT != 0);

  logic [CW-1:0] cnt_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cnt_q <= '0;
    end else if (clr_i) begin
      cnt_q <= '0;
    end else if (en_i) begin
      cnt_q <= cnt_q + CW'(1);
    end
  end

  assign expire_o = ENABLED && en_i && (cnt_q == LAST);

endmodule

// File: rtl/cpu_seq_ctrl.sv
// Multi-cycle FETCH/EXEC/WB sequencer for the RV32I datapath.
// Owns pc, the instruction register, instret and the fetch watchdog.
module cpu_seq_ctrl #(
  parameter logic [31:0] RESET_PC      = 32'h0000_0000,
  parameter int unsigned FETCH_TIMEOUT = 16
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic        stop_req,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  output logic [31:0] inst,
  output logic [31:0] pc,
  input  logic        dec_w_enable,
  output logic        rf_w_enable,
  output logic [2:0]  state,
  output logic        halted,
  output logic        fault,
  output logic [31:0] instret
);

  import cpu_ctrl_pkg::*;

  state_e      state_q;
  logic [31:0] pc_q;
  logic [31:0] inst_q;
  logic [31:0] instret_q;
  logic        halted_q;
  logic        fault_q;

  logic in_fetch;
  logic wd_clr;
  logic wd_en;
  logic wd_expire;

  assign in_fetch = (state_q == ST_FETCH);
  assign wd_en    = in_fetch && !imem_ack;
  assign wd_clr   = !in_fetch || imem_ack;

  fetch_watchdog #(
    .FETCH_TIMEOUT(FETCH_TIMEOUT)
  ) u_wd (
    .clk_i   (clk),
    .rst_ni  (reset),
    .clr_i   (wd_clr),
    .en_i    (wd_en),
    .expire_o(wd_expire)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= ST_IDLE;
      pc_q      <= RESET_PC;
      inst_q    <= INST_NOP;
      instret_q <= '0;
      halted_q  <= 1'b0;
      fault_q   <= 1'b0;
    end else begin
      unique case (state_q)
        ST_IDLE: begin
          if (start) state_q <= ST_FETCH;
        end
        ST_FETCH: begin
          // an ack on the watchdog's last cycle still completes the fetch
          if (imem_ack) begin
            inst_q <= imem_rdata;
            if (is_ebreak(imem_rdata)) begin
              state_q  <= ST_HALT;
              halted_q <= 1'b1;
            end else begin
              state_q <= ST_EXEC;
            end
          end else if (wd_expire) begin
            state_q <= ST_FAULT;
            fault_q <= 1'b1;
          end
        end
        ST_EXEC: begin
          state_q <= ST_WB;
        end
        ST_WB: begin
          pc_q      <= pc_q + PC_STEP;
          instret_q <= instret_q + 32'd1;
          state_q   <= stop_req ? ST_IDLE : ST_FETCH;
        end
        ST_HALT: begin
          // EBREAK is stepped over on resume but never retired
          if (start) begin
            pc_q     <= pc_q + PC_STEP;
            halted_q <= 1'b0;
            state_q  <= ST_FETCH;
          end
        end
        ST_FAULT: begin
          state_q <= ST_FAULT;
        end
        default: begin
          state_q  <= ST_IDLE;
          halted_q <= 1'b0;
        end
      endcase
    end
  end

  assign imem_req    = in_fetch;
  assign imem_addr   = pc_q;
  assign inst        = inst_q;
  assign pc          = pc_q;
  assign instret     = instret_q;
  assign state       = state_q;
  assign halted      = halted_q;
  assign fault       = fault_q;
  assign rf_w_enable = (state_q == ST_WB) && dec_w_enable;

endmodule

// File: tb/tb_cpu_seq_ctrl.sv
// Bench for cpu_seq_ctrl: directed scenarios, then random traffic
// against a cycle-level model of the sequencing rules.
module tb_cpu_seq_ctrl;

  localparam logic [31:0] RPC  = 32'hFFFF_FFF8;
  localparam int          TO   = 16;
  localparam logic [31:0] EBRK = 32'h0010_0073;
  localparam logic [31:0] NOP  = 32'h0000_0013;
  localparam logic [31:0] W1   = 32'h0010_0093;
  localparam logic [31:0] W2   = 32'h0020_8113;
  localparam logic [31:0] W3   = 32'h00a0_0513;
  localparam logic [31:0] W4   = 32'h00c5_8593;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        start = 1'b0;
  logic        stop_req = 1'b0;
  logic        imem_ack = 1'b0;
  logic        dec_w_enable = 1'b0;
  logic [31:0] imem_rdata = '0;
  logic        imem_req;
  logic        rf_w_enable;
  logic        halted;
  logic        fault;
  logic [31:0] imem_addr;
  logic [31:0] inst;
  logic [31:0] pc;
  logic [31:0] instret;
  logic [2:0]  state;

  int n_chk = 0;
  int n_err = 0;

  cpu_seq_ctrl #(
    .RESET_PC(RPC),
    .FETCH_TIMEOUT(TO)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .start       (start),
    .stop_req    (stop_req),
    .imem_req    (imem_req),
    .imem_addr   (imem_addr),
    .imem_ack    (imem_ack),
    .imem_rdata  (imem_rdata),
    .inst        (inst),
    .pc          (pc),
    .dec_w_enable(dec_w_enable),
    .rf_w_enable (rf_w_enable),
    .state       (state),
    .halted      (halted),
    .fault       (fault),
    .instret     (instret)
  );

  always #5 clk = ~clk;

  task automatic chk(
    input string       nm,
    input logic [31:0] act,
    input logic [31:0] exp
  );
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  // Model: st uses the published state codes; fc counts fetch cycles so far.
  typedef struct packed {
    logic [2:0]  st;
    logic [4:0]  fc;
    logic [31:0] pc;
    logic [31:0] inst;
    logic [31:0] ret;
  } mdl_t;

  localparam mdl_t M_RST = '{st: 3'd0, fc: 5'd0, pc: RPC, inst: NOP, ret: 32'd0};

  mdl_t m;

  function automatic mdl_t nxt(input mdl_t c);
    mdl_t n;
    n = c;
    case (c.st)
      3'd0: if (start) n.st = 3'd1;
      3'd1: begin
        n.fc = c.fc + 5'd1;
        if (imem_ack) begin
          n.inst = imem_rdata;
          n.st   = (imem_rdata == EBRK) ? 3'd4 : 3'd2;
          n.fc   = 5'd0;
        end else if (n.fc == 5'(TO)) begin
          n.st = 3'd5;
          n.fc = 5'd0;
        end
      end
      3'd2: n.st = 3'd3;
      3'd3: begin
        n.pc  = c.pc + 32'd4;
        n.ret = c.ret + 32'd1;
        n.st  = stop_req ? 3'd0 : 3'd1;
      end
      3'd4: if (start) begin
        n.pc = c.pc + 32'd4;
        n.st = 3'd1;
      end
      default: n = c;
    endcase
    return n;
  endfunction

  always @(posedge clk or negedge reset) begin
    if (!reset) m <= M_RST;
    else m <= nxt(m);
  end

  always @(negedge clk) begin
    #1;
    chk("state", 32'(state), 32'(m.st));
    chk("pc", pc, m.pc);
    chk("imem_addr", imem_addr, m.pc);
    chk("imem_req", 32'(imem_req), 32'(m.st == 3'd1));
    chk("inst", inst, m.inst);
    chk("instret", instret, m.ret);
    chk("halted", 32'(halted), 32'(m.st == 3'd4));
    chk("fault", 32'(fault), 32'(m.st == 3'd5));
    chk("rf_w_enable", 32'(rf_w_enable), 32'(m.st == 3'd3 && dec_w_enable));
  end

  int          wait_cfg = 0;
  int          wcnt = 0;
  logic [31:0] next_word = W1;
  bit          rnd = 1'b0;

  task automatic respond();
    int r;
    if (imem_req) begin
      if (wcnt == wait_cfg) begin
        imem_ack   = 1'b1;
        imem_rdata = next_word;
        wcnt       = 0;
        if (rnd) begin
          next_word = ($urandom_range(0, 7) == 0) ? EBRK : $urandom;
          r = $urandom_range(0, 31);
          wait_cfg = (r < 24) ? r % 4 : ((r < 30) ? 15 : 16);
        end
      end else begin
        imem_ack   = 1'b0;
        imem_rdata = $urandom;
        wcnt++;
      end
    end else begin
      wcnt       = 0;
      imem_ack   = rnd ? 1'($urandom_range(0, 1)) : 1'b0;
      imem_rdata = $urandom;
    end
    if (rnd) begin
      start        = ($urandom_range(0, 3) == 0);
      stop_req     = ($urandom_range(0, 7) == 0);
      dec_w_enable = 1'($urandom_range(0, 1));
    end
  endtask

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
      respond();
      @(negedge clk);
    end
  endtask

  initial begin
    step(2);
    chk("rst_state", 32'(state), 32'd0);
    chk("rst_pc", pc, RPC);
    chk("rst_inst", inst, NOP);
    chk("rst_instret", instret, 32'd0);
    chk("rst_req", 32'(imem_req), 32'd0);

    reset = 1'b1;
    start = 1'b1;
    dec_w_enable = 1'b1;
    step(1);
    chk("c1_req", 32'(imem_req), 32'd1);
    chk("c1_addr", imem_addr, RPC);
    start = 1'b0;
    step(1);
    chk("c2_exec", 32'(state), 32'd2);
    chk("c2_rf", 32'(rf_w_enable), 32'd0);
    next_word = W2;
    wait_cfg  = 3;
    step(1);
    chk("c3_rf", 32'(rf_w_enable), 32'd1);
    step(1);
    chk("c4_pc", pc, 32'hFFFF_FFFC);
    chk("c4_instret", instret, 32'd1);
    chk("c4_rf", 32'(rf_w_enable), 32'd0);
    for (int k = 0; k < 4; k++) begin
      chk("wait_addr", imem_addr, 32'hFFFF_FFFC);
      chk("wait_inst", inst, W1);
      chk("wait_state", 32'(state), 32'd1);
      if (k < 3) step(1);
    end
    next_word = EBRK;
    wait_cfg  = 0;
    step(1);
    chk("late_inst", inst, W2);
    step(2);
    chk("wrap_pc", pc, 32'd0);
    chk("wrap_instret", instret, 32'd2);
    step(1);
    chk("halt_state", 32'(state), 32'd4);
    chk("halt_flag", 32'(halted), 32'd1);
    chk("halt_pc", pc, 32'd0);
    chk("halt_inst", inst, EBRK);
    step(1);
    chk("halt_hold", 32'(state), 32'd4);
    start     = 1'b1;
    stop_req  = 1'b1;
    next_word = W3;
    step(1);
    chk("resume_addr", imem_addr, 32'd4);
    chk("resume_halted", 32'(halted), 32'd0);
    start = 1'b0;
    step(3);
    chk("stop_state", 32'(state), 32'd0);
    chk("stop_pc", pc, 32'd8);
    chk("stop_instret", instret, 32'd3);
    stop_req   = 1'b0;
    imem_ack   = 1'b1;
    imem_rdata = EBRK;
    step(1);
    chk("stray_ack_state", 32'(state), 32'd0);
    chk("stray_ack_inst", inst, W3);

    start    = 1'b1;
    wait_cfg = -1;
    step(16);
    chk("to_last", 32'(state), 32'd1);
    step(1);
    chk("to_fault_state", 32'(state), 32'd5);
    chk("to_fault", 32'(fault), 32'd1);
    chk("to_req", 32'(imem_req), 32'd0);
    step(2);
    chk("fault_sticky", 32'(state), 32'd5);
    #2 reset = 1'b0;
    #1;
    chk("fault_clr", 32'(fault), 32'd0);
    chk("fault_rst_state", 32'(state), 32'd0);
    step(1);
    reset     = 1'b1;
    wait_cfg  = 15;
    next_word = W4;
    step(16);
    chk("edge_fetch", 32'(state), 32'd1);
    step(1);
    chk("edge_exec", 32'(state), 32'd2);
    chk("edge_nofault", 32'(fault), 32'd0);
    chk("edge_inst", inst, W4);
    start = 1'b0;
    step(1);
    chk("wb_rf", 32'(rf_w_enable), 32'd1);
    #2 reset = 1'b0;
    #1;
    chk("async_rf", 32'(rf_w_enable), 32'd0);
    chk("async_pc", pc, RPC);
    chk("async_instret", instret, 32'd0);
    step(1);
    reset = 1'b1;

    rnd      = 1'b1;
    wait_cfg = 0;
    repeat (4000) begin
      step(1);
      if ($urandom_range(0, 299) == 0 || (fault && $urandom_range(0, 9) == 0)) begin
        #2 reset = 1'b0;
        step(1);
        reset = 1'b1;
      end
    end

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule
